fa_nbit_seq: RTL and testbench
==============================

Name: fa_nbit_seq

Overview:
- Parametrised, multi-cycle adder/subtractor; the sequential successor to the 1-bit and 4-bit full adders.
- Splits WIDTH-bit operands into CHUNK-bit slices and adds one slice per clock, LSB slice first, through a registered carry.
- Supports add and subtract modes and reports carry-out and signed overflow.
- Uses a start/busy/done handshake so a datapath controller can trade latency for adder width.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NSTEP (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request a new operation; sampled only in IDLE or DONE.
- i_sub  input  1  0 = a + b + ci; 1 = a - b (computed as a + ~b + 1; i_ci ignored).
- i_a  input  WIDTH  operand A, unsigned or two's complement.
- i_b  input  WIDTH  operand B.
- i_ci  input  1  carry-in, used in add mode only.
- o_busy  output  1  high while an operation is in progress (state RUN).
- o_done  output  1  one-cycle pulse when results update.
- o_s  output  WIDTH  registered sum/difference.
- o_co  output  1  carry-out of the MSB; in subtract mode 1 = no borrow.
- o_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; step counter, carry and accumulators cleared.
  - o_busy = 0, o_done = 0, o_s = 0, o_co = 0, o_ovf = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_start = 1 at a rising edge -> RUN.
  - RUN: step counter runs 0..NSTEP-1; after slice NSTEP-1 -> DONE.
  - DONE: lasts exactly one cycle. i_start = 1 -> RUN (back-to-back); otherwise -> IDLE.
- Start acceptance (edge T0):
  - Latch i_a.
  - Latch b_eff = i_sub ? ~i_b : i_b.
  - Set carry = i_sub ? 1 : i_ci; step = 0.
  - i_start in RUN is ignored, with no effect on the operation in flight.
- RUN cycle k (k = 0..NSTEP-1):
  - {carry, acc[k*CHUNK +: CHUNK]} <= a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry.
  - On the last slice, also capture the carry into the MSB to compute overflow.
- Completion:
  - At edge T0 + NSTEP: o_s <= full accumulated result, o_co <= final carry, o_ovf <= carry_into_msb XOR carry_out.
  - The same edge sets o_done = 1, held for exactly one cycle.
  - Latency from the start-accept edge to the result/o_done edge is NSTEP cycles; with CHUNK = WIDTH it is 1 cycle.
- o_busy: 1 from edge T0 through the cycle before completion; 0 in IDLE and DONE.
- Output stability: o_s, o_co and o_ovf change only at completion edges and hold between operations. Partial results are never visible on the outputs.
- Input timing: operands may change freely after the accept edge.
- Wrap-around: the result is modulo 2^WIDTH; the carry propagates across every slice boundary.
- Simultaneous events:
  - i_start in the DONE cycle: the new operation starts; o_done still pulses for the finished one.
  - rst_n low overrides everything.
- Reset mid-operation: the operation is aborted with no o_done pulse; all outputs return to reset values.

Test Plan (WIDTH = 16, CHUNK = 4 unless noted):
- Add, i_a = 0x1234, i_b = 0x4321, i_ci = 0, i_sub = 0 -> o_s = 0x5555, o_co = 0, o_ovf = 0. o_busy high for 4 cycles; o_done pulses 4 cycles after the accept edge.
- Full carry chain, i_a = 0xFFFF, i_b = 0x0001, i_ci = 0 -> o_s = 0x0000, o_co = 1, o_ovf = 0.
- Signed overflow, i_a = 0x7FFF, i_b = 0x0001 -> o_s = 0x8000, o_co = 0, o_ovf = 1. With i_ci = 1 and i_a = i_b = 0x0000 -> o_s = 0x0001.
- Subtract, i_a = 0x0005, i_b = 0x0007, i_sub = 1 -> o_s = 0xFFFE, o_co = 0, o_ovf = 0. Then i_a = 0x0007, i_b = 0x0005 -> o_s = 0x0002, o_co = 1.
- Control:
  - i_start pulsed during RUN -> ignored; the result matches the first operands.
  - i_start in the DONE cycle -> second result exactly 4 cycles later.
  - rst_n low during step 2 -> o_busy = 0, o_done never pulses, o_s = 0.
- 1000 random {i_sub, i_ci, i_a, i_b} cases checked against a+b+ci and a-b, for (CHUNK = 4, WIDTH = 16), (1, 8) and (8, 8). For CHUNK = WIDTH the latency must be 1 cycle.

Source files
------------

// File: rtl/fa_nbit_seq.sv
// fa_nbit_seq: multi-cycle adder/subtractor that processes one CHUNK-bit
// slice per clock, LSB slice first, through a registered carry.
//
// Handshake: i_start is accepted only when the FSM is in IDLE or DONE.
// The accept edge latches the operands, and the block then runs NSTEP
// cycles. At the completion edge o_s/o_co/o_ovf update and o_done goes
// high for exactly one cycle. o_busy is high for every cycle in RUN, and
// i_start is ignored while o_busy is high. There is no backpressure on
// the result side.
//
// WIDTH must be an integer multiple of CHUNK, and 1 <= CHUNK <= WIDTH.
module fa_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf,
  output logic [1:0]       o_state
);

  localparam int NSTEP = WIDTH / CHUNK;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic             carry;
  logic [WIDTH-1:0] acc;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] result;
  logic             c_into_msb;
  logic             start_ok;

  // Slice adder for the current step, plus the final-result assembly used on the last step
  always_comb begin
    base       = 32'(step) * 32'(CHUNK);
    a_slice    = a_q[base +: CHUNK];
    b_slice    = b_q[base +: CHUNK];
    slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
    // The last slice is the top slice, so its sum lands in the MSBs.
    result     = acc;
    result[WIDTH-1 -: CHUNK] = slice_sum[CHUNK-1:0];
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    c_into_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[CHUNK-1];
    start_ok   = i_start && ((state == S_IDLE) || (state == S_DONE));
  end

  // FSM, operand latch, slice accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      acc   <= '0;
      o_s   <= '0;
      o_co  <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          acc[base +: CHUNK] <= slice_sum[CHUNK-1:0];
          carry              <= slice_sum[CHUNK];
          if (step == LAST_STEP) begin
            o_s   <= result;
            o_co  <= slice_sum[CHUNK];
            o_ovf <= c_into_msb ^ slice_sum[CHUNK];
            state <= S_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation.
          if (start_ok) begin
            a_q   <= i_a;
            b_q   <= i_sub ? ~i_b : i_b;
            carry <= i_sub ? 1'b1 : i_ci;
            step  <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    o_busy  = (state == S_RUN);
    o_done  = (state == S_DONE);
    o_state = state;
  end

endmodule

// File: tb/tb_fa_nbit_seq.sv
// tb_fa_nbit_seq: directed and randomized checks of fa_nbit_seq for the
// (WIDTH, CHUNK) configurations (16, 4), (8, 1) and (8, 8). The expected
// results come from an integer-arithmetic reference model.
module tb_fa_nbit_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        sub;
  logic        ci;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  start;

  logic        busy0, done0, co0, ovf0;
  logic [15:0] s0;
  logic [1:0]  st0;
  logic        busy1, done1, co1, ovf1;
  logic [7:0]  s1;
  logic [1:0]  st1;
  logic        busy2, done2, co2, ovf2;
  logic [7:0]  s2;
  logic [1:0]  st2;

  fa_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_sub(sub), .i_a(a), .i_b(b),
    .i_ci(ci), .o_busy(busy0), .o_done(done0), .o_s(s0), .o_co(co0), .o_ovf(ovf0),
    .o_state(st0)
  );

  fa_nbit_seq #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_sub(sub), .i_a(a[7:0]), .i_b(b[7:0]),
    .i_ci(ci), .o_busy(busy1), .o_done(done1), .o_s(s1), .o_co(co1), .o_ovf(ovf1),
    .o_state(st1)
  );

  fa_nbit_seq #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_sub(sub), .i_a(a[7:0]), .i_b(b[7:0]),
    .i_ci(ci), .o_busy(busy2), .o_done(done2), .o_s(s2), .o_co(co2), .o_ovf(ovf2),
    .o_state(st2)
  );

  // Output mux for the DUT currently under test
  int          sel;
  logic        sel_busy, sel_done, sel_co, sel_ovf;
  logic [15:0] sel_s;
  logic [1:0]  sel_state;

  always_comb begin
    sel_busy  = busy0;
    sel_done  = done0;
    sel_co    = co0;
    sel_ovf   = ovf0;
    sel_s     = s0;
    sel_state = st0;
    if (sel == 1) begin
      sel_busy = busy1; sel_done = done1; sel_co = co1; sel_ovf = ovf1;
      sel_s = {8'h00, s1}; sel_state = st1;
    end else if (sel == 2) begin
      sel_busy = busy2; sel_done = done2; sel_co = co2; sel_ovf = ovf2;
      sel_s = {8'h00, s2}; sel_state = st2;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int which);
    return (which == 0) ? 16 : 8;
  endfunction

  function automatic int nstep_of(input int which);
    if (which == 0) return 4;
    if (which == 1) return 8;
    return 1;
  endfunction

  // Reference model: plain integer arithmetic on unsigned and signed views
  task automatic model(input int w, input logic op_sub, input logic op_ci,
                       input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] es, output logic eco, output logic eovf);
    longint full, half, mask, ua, ub, sa, sb, r, sr;
    full = longint'(1) << w;
    half = full >> 1;
    mask = full - 1;
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    if (op_sub) begin
      r   = ua - ub;
      eco = (ua >= ub);
      sr  = sa - sb;
    end else begin
      r   = ua + ub + longint'(op_ci);
      eco = (r >= full);
      sr  = sa + sb + longint'(op_ci);
    end
    eovf = (sr < -half) || (sr > half - 1);
    es   = 16'(r & mask);
  endtask

  // ---------------- driver tasks ----------------
  // Waits for o_done after the accept edge; lat = edges counted, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (sel_busy) busy_cnt++;
      @(posedge clk); #1;
      if (sel_done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input int which, input logic op_sub, input logic op_ci,
                        input logic [15:0] av, input logic [15:0] bv, input string tag);
    logic [15:0] es;
    logic        eco, eovf;
    int          lat, busy_cnt;
    model(width_of(which), op_sub, op_ci, av, bv, es, eco, eovf);
    exp_q.push_back(es);
    sel = which;
    @(negedge clk);
    a = av; b = bv; sub = op_sub; ci = op_ci;
    start[which] = 1'b1;
    @(posedge clk); #1;
    start[which] = 1'b0;
    // Operands are free to change after the accept edge.
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
    wait_done(lat, busy_cnt);
    if (lat < 0) begin
      chk({tag, "_timeout"}, 32'(lat), 32'(nstep_of(which)));
    end else begin
      chk({tag, "_lat"},  32'(lat),      32'(nstep_of(which)));
      chk({tag, "_busy"}, 32'(busy_cnt), 32'(nstep_of(which)));
      chk({tag, "_s"},    32'(sel_s),    32'(exp_q.pop_front()));
      chk({tag, "_co"},   32'(sel_co),   32'(eco));
      chk({tag, "_ovf"},  32'(sel_ovf),  32'(eovf));
      chk({tag, "_busy_in_done"}, 32'(sel_busy), 32'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy0"}, 32'({busy0, done0, co0, ovf0}), 32'(0));
    chk({tag, "_s0"},    32'(s0), 32'(0));
    chk({tag, "_busy1"}, 32'({busy1, done1, co1, ovf1}), 32'(0));
    chk({tag, "_s1"},    32'(s1), 32'(0));
    chk({tag, "_busy2"}, 32'({busy2, done2, co2, ovf2}), 32'(0));
    chk({tag, "_s2"},    32'(s2), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, busy_cnt, seen;
    logic [15:0] idle_s;
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    start    = '0;
    sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on the 16/4 configuration
    run_op(0, 1'b0, 1'b0, 16'h1234, 16'h4321, "add_basic");
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done0), 32'(0));
    chk("hold_s",         32'(s0),    32'h5555);
    run_op(0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, "carry_chain");
    run_op(0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, "signed_ovf");
    run_op(0, 1'b0, 1'b1, 16'h0000, 16'h0000, "carry_in");
    run_op(0, 1'b1, 1'b0, 16'h0005, 16'h0007, "sub_borrow");
    run_op(0, 1'b1, 1'b1, 16'h0007, 16'h0005, "sub_noborrow");
    run_op(0, 1'b1, 1'b0, 16'h8000, 16'h0001, "sub_ovf");

    // Back-to-back: the second run_op raises i_start in the DONE cycle
    run_op(0, 1'b0, 1'b0, 16'h0F0F, 16'h0101, "b2b_first");
    run_op(0, 1'b0, 1'b0, 16'h1111, 16'h2222, "b2b_second");

    // i_start pulsed in RUN must not disturb the operation in flight
    repeat (2) @(negedge clk);
    sel = 0;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; ci = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; ci = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    // Two edges (accept + one RUN edge) have already passed.
    lat = -1;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (done0) begin lat = cyc; break; end
    end
    chk("run_start_lat", 32'(lat), 32'(4));
    chk("run_start_s",   32'(s0),  32'h3333);
    @(posedge clk); #1;
    chk("run_start_no_restart", 32'(busy0), 32'(0));

    // Reset during step 2 aborts the operation
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; sub = 1'b0; ci = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy0), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 32'(0));
    chk("abort_s",    32'(s0),    32'(0));
    chk("abort_flags", 32'({co0, ovf0, done0}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (done0 || busy0) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'(0));
    idle_s = s0;
    chk("abort_s_hold", 32'(idle_s), 32'(0));

    // Randomized cases on all three configurations
    for (int which = 0; which < 3; which++) begin
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        run_op(which, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               $sformatf("rand_w%0d", which));
      end
      repeat (2) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
